// File: rtl/pps_freq_stat_pkg.sv
// Shared definitions for the PPS frequency statistics block: deviation width,
// saturation limits, FSM state encoding and the deviation saturation helper.
// No logic of its own; imported by pps_freq_stat and its window sub-module.
package pps_freq_stat_pkg;

  localparam int unsigned NOMINAL_DEF = 100_000_000;
  localparam int          DEV_W       = 24;

  localparam logic signed [DEV_W-1:0] DEV_MAX = 24'sh7F_FFFF;
  localparam logic signed [DEV_W-1:0] DEV_MIN = 24'sh80_0000;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    ACQ    = 2'd1,
    LOCK   = 2'd2
  } state_e;

  // Clamp a 29-bit signed deviation into the 24-bit signed output range.
  function automatic logic signed [DEV_W-1:0] sat_dev(input logic signed [28:0] d);
    if (d > 29'sd8388607) begin
      return DEV_MAX;
    end else if (d < -29'sd8388608) begin
      return DEV_MIN;
    end else begin
      return d[DEV_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pps_freq_stat_dev_window.sv
// Moving-average ring: 2^AVG_LOG2 deviations with a running sum and fill count.
// Latency: sum_o/full_o reflect a push on the cycle after push_i.
// No backpressure: one push per cycle at most; clr_i wins over push_i.
module pps_freq_stat_dev_window
  import pps_freq_stat_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               push_i,
  input  logic signed [DEV_W-1:0]            din_i,
  input  logic                               clr_i,
  output logic signed [DEV_W+AVG_LOG2-1:0]   sum_o,
  output logic                               full_o
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DEV_W + AVG_LOG2;

  logic signed [DEV_W-1:0] mem_q [DEPTH];
  logic [AVG_LOG2-1:0]     wptr_q;
  logic [AVG_LOG2:0]       fill_q;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [SUM_W-1:0] din_x, old_x;
  logic                    full;

  // fill_q saturates at DEPTH, so its top bit alone marks a full window.
  assign full  = fill_q[AVG_LOG2];
  assign din_x = SUM_W'(din_i);
  assign old_x = SUM_W'(mem_q[wptr_q]);

  // Running sum: once full, the entry being overwritten leaves the sum.
  always_comb begin
    sum_d = sum_q;
    if (push_i) begin
      sum_d = full ? (sum_q + din_x - old_x) : (sum_q + din_x);
    end
  end

  // Ring storage needs no reset: stale entries are never read before overwrite.
  always_ff @(posedge i_clk) begin
    if (push_i && !clr_i) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  // Pointer, fill count and sum; clearing empties the window.
  always_ff @(posedge i_clk) begin
    if (i_rst || clr_i) begin
      wptr_q <= '0;
      fill_q <= '0;
      sum_q  <= '0;
    end else if (push_i) begin
      wptr_q <= wptr_q + AVG_LOG2'(1);
      if (!full) begin
        fill_q <= fill_q + (AVG_LOG2+1)'(1);
      end
      sum_q <= sum_d;
    end
  end

  assign sum_o  = sum_q;
  assign full_o = full;

endmodule

// File: rtl/pps_freq_stat.sv
// PPS count statistics: deviation, tolerance gate, moving average, lock FSM, miss timeout.
// Latency: i_freq_en at N -> o_valid/o_reject and updated outputs at N+2; no backpressure.
// Optional min/max trackers built only with PPS_FREQ_STAT_MINMAX_EN defined (else tied 0).
module pps_freq_stat
  import pps_freq_stat_pkg::*;
#(
  parameter int unsigned NOMINAL  = NOMINAL_DEF,
  parameter int unsigned TOL      = 1000,
  parameter int          AVG_LOG2 = 3,
  parameter int          LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 150_000_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_freq_en,
  input  logic [27:0]             i_freq,
  output logic                    o_valid,
  output logic                    o_reject,
  output logic signed [DEV_W-1:0] o_dev,
  output logic signed [DEV_W-1:0] o_dev_avg,
  output logic                    o_avg_valid,
  output logic signed [DEV_W-1:0] o_dev_min,
  output logic signed [DEV_W-1:0] o_dev_max,
  output logic                    o_lock,
  output logic                    o_miss
);

  localparam int SUM_W  = DEV_W + AVG_LOG2;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic signed [28:0] NOM_S   = 29'(NOMINAL);
  localparam logic signed [28:0] TOL_S   = 29'(TOL);
  localparam logic [27:0]        TMO_MAX = 28'(TIMEOUT);
  localparam logic [27:0]        TMO_PRE = 28'(TIMEOUT - 1);

  // ---------------- stage 1: deviation and window test ----------------
  logic signed [28:0]      dev_raw;
  logic                    s1_vld_q;
  logic signed [DEV_W-1:0] s1_dev_q;
  logic                    s1_win_q;

  assign dev_raw = $signed({1'b0, i_freq}) - NOM_S;

  // Capture the saturated deviation and in-window flag for each new count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld_q <= 1'b0;
      s1_dev_q <= '0;
      s1_win_q <= 1'b0;
    end else begin
      s1_vld_q <= i_freq_en;
      if (i_freq_en) begin
        s1_dev_q <= sat_dev(dev_raw);
        s1_win_q <= (dev_raw <= TOL_S) && (dev_raw >= -TOL_S);
      end
    end
  end

  // ---------------- missing-PPS timeout ----------------
  logic [27:0] tmo_q;
  logic        miss_q;
  logic        tmo_hit;

  // A strobe in the reaching cycle wins, so the hit only counts without one.
  assign tmo_hit = !i_freq_en && (tmo_q == TMO_PRE);

  // Cycles since the last strobe, saturating; miss flag held until next strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_q  <= '0;
      miss_q <= 1'b0;
    end else if (i_freq_en) begin
      tmo_q  <= '0;
      miss_q <= 1'b0;
    end else begin
      if (tmo_q != TMO_MAX) begin
        tmo_q <= tmo_q + 28'd1;
      end
      if (tmo_hit) begin
        miss_q <= 1'b1;
      end
    end
  end

  // ---------------- stage 2: lock FSM ----------------
  state_e            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              accept, reject, clr_win;

  // State and consecutive-good counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= UNLOCK;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Next state and accept/reject decision; timeout overrides any sample.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    accept  = 1'b0;
    reject  = 1'b0;
    clr_win = 1'b0;
    if (tmo_hit) begin
      state_d = UNLOCK;
      good_d  = '0;
      clr_win = 1'b1;
    end else if (s1_vld_q) begin
      unique case (state_q)
        UNLOCK: begin
          // First interval after losing PPS is partial: drop it silently.
          state_d = ACQ;
          good_d  = '0;
        end
        ACQ: begin
          if (s1_win_q) begin
            accept = 1'b1;
            if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
              state_d = LOCK;
              good_d  = GOOD_W'(LOCK_CNT);
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else begin
            reject = 1'b1;
            good_d = '0;
          end
        end
        LOCK: begin
          if (s1_win_q) begin
            accept = 1'b1;
          end else begin
            reject  = 1'b1;
            state_d = ACQ;
            good_d  = '0;
          end
        end
        default: begin
          state_d = UNLOCK;
          good_d  = '0;
        end
      endcase
    end
  end

  // ---------------- stage 2: outputs and window ----------------
  logic                    valid_q, reject_q;
  logic signed [DEV_W-1:0] dev_q;
  logic signed [SUM_W-1:0] win_sum;
  logic                    win_full;
  logic                    unused_sum_lsb;

  // Result pulses and last accepted deviation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
      dev_q    <= '0;
    end else begin
      valid_q  <= accept;
      reject_q <= reject;
      if (accept) begin
        dev_q <= s1_dev_q;
      end
    end
  end

  pps_freq_stat_dev_window #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_dev_window (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .push_i (accept),
    .din_i  (s1_dev_q),
    .clr_i  (clr_win),
    .sum_o  (win_sum),
    .full_o (win_full)
  );

  // Dropping the low bits of a two's-complement sum is a floor division.
  assign o_dev_avg      = win_sum[SUM_W-1:AVG_LOG2];
  assign unused_sum_lsb = ^win_sum[AVG_LOG2-1:0];

`ifdef PPS_FREQ_STAT_MINMAX_EN
  logic signed [DEV_W-1:0] min_q, max_q;
  logic                    seen_q;

  // Extremes since the last UNLOCK; outputs read 0 until something is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst || clr_win) begin
      min_q  <= DEV_MAX;
      max_q  <= DEV_MIN;
      seen_q <= 1'b0;
    end else if (accept) begin
      seen_q <= 1'b1;
      if (s1_dev_q < min_q) begin
        min_q <= s1_dev_q;
      end
      if (s1_dev_q > max_q) begin
        max_q <= s1_dev_q;
      end
    end
  end

  assign o_dev_min = seen_q ? min_q : '0;
  assign o_dev_max = seen_q ? max_q : '0;
`else
  assign o_dev_min = '0;
  assign o_dev_max = '0;
`endif

  assign o_valid     = valid_q;
  assign o_reject    = reject_q;
  assign o_dev       = dev_q;
  assign o_avg_valid = win_full;
  assign o_lock      = (state_q == LOCK);
  assign o_miss      = miss_q;

endmodule

// File: tb/tb_pps_freq_stat.sv
// Bench for pps_freq_stat: directed scenarios plus randomized samples,
// each result checked against a queue-based reference model two cycles after the strobe.
// Uses a shortened timeout so the miss path is exercised quickly.
module tb_pps_freq_stat;

  localparam int NOM = 100_000_000;
  localparam int TOL = 1000;
  localparam int WIN = 8;
  localparam int LCK = 4;
  localparam int T   = 2000;

  logic               i_clk, i_rst, i_freq_en;
  logic [27:0]        i_freq;
  logic               o_valid, o_reject, o_avg_valid, o_lock, o_miss;
  logic signed [23:0] o_dev, o_dev_avg, o_dev_min, o_dev_max;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int hist[$];
  bit disc;
  int streak;
  bit locked;
  bit miss;
  int last_dev;
  int e_valid, e_rej;

  pps_freq_stat #(
    .NOMINAL  (NOM),
    .TOL      (TOL),
    .AVG_LOG2 (3),
    .LOCK_CNT (LCK),
    .TIMEOUT  (T)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_freq_en   (i_freq_en),
    .i_freq      (i_freq),
    .o_valid     (o_valid),
    .o_reject    (o_reject),
    .o_dev       (o_dev),
    .o_dev_avg   (o_dev_avg),
    .o_avg_valid (o_avg_valid),
    .o_dev_min   (o_dev_min),
    .o_dev_max   (o_dev_max),
    .o_lock      (o_lock),
    .o_miss      (o_miss)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    disc = 1; streak = 0; locked = 0; miss = 0; last_dev = 0;
    e_valid = 0; e_rej = 0;
  endfunction

  function automatic void model_timeout();
    hist.delete();
    disc = 1; streak = 0; locked = 0; miss = 1;
    e_valid = 0; e_rej = 0;
  endfunction

  function automatic void model_sample(input logic [27:0] f);
    longint d;
    d = longint'(f) - longint'(NOM);
    if (d > 8388607)  d = 8388607;
    if (d < -8388608) d = -8388608;
    miss = 0; e_valid = 0; e_rej = 0;
    if (disc) begin
      disc = 0;
    end else if (d <= TOL && d >= -TOL) begin
      hist.push_back(int'(d));
      last_dev = int'(d);
      streak++;
      if (streak >= LCK) locked = 1;
      e_valid = 1;
    end else begin
      streak = 0;
      locked = 0;
      e_rej = 1;
    end
  endfunction

  // floor of the mean-sum over the newest (up to) WIN accepted deviations
  function automatic int model_avg();
    int s = 0;
    int n = hist.size();
    int lo = (n > WIN) ? n - WIN : 0;
    for (int i = lo; i < n; i++) s += hist[i];
    return (s >= 0) ? s / WIN : -((-s + WIN - 1) / WIN);
  endfunction

  function automatic int model_min();
    int m = 0;
`ifdef PPS_FREQ_STAT_MINMAX_EN
    if (hist.size() > 0) m = hist[0];
    foreach (hist[i]) if (hist[i] < m) m = hist[i];
`endif
    return m;
  endfunction

  function automatic int model_max();
    int m = 0;
`ifdef PPS_FREQ_STAT_MINMAX_EN
    if (hist.size() > 0) m = hist[0];
    foreach (hist[i]) if (hist[i] > m) m = hist[i];
`endif
    return m;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"},     o_valid, e_valid);
    chk({tag, ".reject"},    o_reject, e_rej);
    chk({tag, ".dev"},       o_dev, last_dev);
    chk({tag, ".avg"},       o_dev_avg, model_avg());
    chk({tag, ".avg_valid"}, o_avg_valid, (hist.size() >= WIN) ? 1 : 0);
    chk({tag, ".min"},       o_dev_min, model_min());
    chk({tag, ".max"},       o_dev_max, model_max());
    chk({tag, ".lock"},      o_lock, int'(locked));
    chk({tag, ".miss"},      o_miss, int'(miss));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // called at a negedge; returns at the negedge two edges after the strobe
  task automatic send(input string tag, input logic [27:0] f);
    i_freq_en = 1'b1;
    i_freq    = f;
    @(negedge i_clk);
    i_freq_en = 1'b0;
    chk({tag, ".lat_valid"},  o_valid, 0);
    chk({tag, ".lat_reject"}, o_reject, 0);
    @(negedge i_clk);
    model_sample(f);
    check_all(tag);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_freq_en = 1'b0;
    @(negedge i_clk);
    model_reset();
    check_all("reset");
    i_rst = 1'b0;
  endtask

  initial begin
    int dv, r;
    logic [27:0] f;
    i_rst = 1'b1; i_freq_en = 1'b0; i_freq = '0;
    idle(3);
    do_reset();

    // acquire: first sample dropped, four more reach LOCK
    for (int i = 0; i < 5; i++) send("acq", 28'(NOM));
    // out-of-window in LOCK, then re-lock on +10
    send("rej_lock", 28'(NOM + 1001));
    for (int i = 0; i < 4; i++) send("relock", 28'(NOM + 10));
    // tolerance edges
    send("tol_hi", 28'(NOM + TOL));
    send("tol_lo", 28'(NOM - TOL));
    send("tol_out", 28'(NOM - TOL - 1));

    // average over +1..+8 from a fresh window
    do_reset();
    idle(2);
    send("disc", 28'(NOM + 5));
    for (int i = 1; i <= 8; i++) send("ramp", 28'(NOM + i));
    for (int i = 0; i < 8; i++) send("neg3", 28'(NOM - 3));
    send("neg4", 28'(NOM - 4));

    // strobe in the very cycle the counter would expire: no miss
    idle(T - 2);
    chk("edge.miss", o_miss, 0);
    send("edge", 28'(NOM + 2));

    // real timeout
    idle(T - 2);
    chk("tmo_early.miss", o_miss, 0);
    chk("tmo_early.lock", o_lock, 1);
    idle(1);
    model_timeout();
    check_all("tmo");
    send("after_tmo", 28'(NOM));
    for (int i = 0; i < 4; i++) send("reacq", 28'(NOM - 7));
    send("sat_lo", 28'd0);
    send("sat_hi", 28'hFFF_FFFF);

    // reset while a sample sits in stage 1
    i_freq_en = 1'b1; i_freq = 28'(NOM);
    @(negedge i_clk);
    i_freq_en = 1'b0; i_rst = 1'b1;
    @(negedge i_clk);
    model_reset();
    check_all("midrst");
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("midrst.drop_valid", o_valid, 0);
    chk("midrst.drop_rej",   o_reject, 0);

    // randomized samples
    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        dv = int'($urandom_range(0, 2 * TOL)) - TOL;
        f  = 28'(NOM + dv);
      end else if (r == 7) begin
        dv = TOL + 1 + int'($urandom_range(0, 5000));
        f  = 28'(($urandom_range(0, 1) == 1) ? NOM + dv : NOM - dv);
      end else if (r == 8) begin
        f = 28'($urandom);
      end else begin
        f = 28'(($urandom_range(0, 1) == 1) ? NOM + TOL : NOM - TOL);
      end
      send("rnd", f);
      idle(int'($urandom_range(0, 20)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
